// File: rtl/mul_pkg.sv
// Shared types and defaults for the multiplier arbiter and its round-robin picker.
// Holds the FSM state encoding, the client index type and the default geometry.
package mul_pkg;

    localparam int MUL_WIDTH_DEF   = 8;
    localparam int MUL_TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } mul_arb_state_t;

    typedef logic client_idx_t;

endpackage

// File: rtl/mul_arbiter_rr_arb2.sv
// Two-way round-robin pick, purely combinational (zero latency, no backpressure).
// A lone request always wins; on contention the client named by ptr wins.
module rr_arb2
    import mul_pkg::*;
(
    input  logic        req0,
    input  logic        req1,
    input  client_idx_t ptr,
    output logic        valid,
    output client_idx_t idx
);

    assign valid = req0 | req1;
    assign idx   = (req0 & req1) ? ptr : req1;

endmodule

// File: rtl/mul_arbiter.sv
// Shares one sequential multiplier between two clients: round-robin grant, start, wait, done.
// Overhead 3 cycles plus multiplier latency; clients hold req until gnt, watchdog aborts a stuck job.
module mul_arbiter
    import mul_pkg::*;
#(
    parameter int width   = MUL_WIDTH_DEF,
    parameter int TIMEOUT = MUL_TIMEOUT_DEF
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic [width-1:0]     opa0,
    input  logic [width-1:0]     opb0,
    input  logic                 req1,
    input  logic [width-1:0]     opa1,
    input  logic [width-1:0]     opb1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 done0,
    output logic                 done1,
    output logic [2*width-1:0]   prod,
    output logic                 err,
    output logic                 busy,
    output logic                 mul_start,
    output logic [width-1:0]     mul_opa,
    output logic [width-1:0]     mul_opb,
    input  logic                 mul_done,
    input  logic [2*width-1:0]   mul_prod
);

    localparam int                CNT_W    = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    mul_arb_state_t      r_state;
    mul_arb_state_t      w_state_nxt;
    client_idx_t         r_sel;
    client_idx_t         r_ptr;
    logic [width-1:0]    r_opa;
    logic [width-1:0]    r_opb;
    logic [2*width-1:0]  r_prod;
    logic                r_err;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_expire;
    logic                w_arb_vld;
    client_idx_t         w_arb_idx;

    rr_arb2 u_rr_arb2 (
        .req0  (req0),
        .req1  (req1),
        .ptr   (r_ptr),
        .valid (w_arb_vld),
        .idx   (w_arb_idx)
    );

    // The abort fires on the WAIT cycle whose incremented count hits TIMEOUT-1,
    // which places the error DONE exactly TIMEOUT cycles after ISSUE.
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_expire  = (w_cnt_inc == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_arb_vld) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (mul_done || w_expire) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sel  <= 1'b0;
            r_ptr  <= 1'b0;
            r_opa  <= '0;
            r_opb  <= '0;
            r_prod <= '0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_vld) begin
                        r_sel <= w_arb_idx;
                        r_opa <= w_arb_idx ? opa1 : opa0;
                        r_opb <= w_arb_idx ? opb1 : opb0;
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= '0;
                end
                ST_WAIT: begin
                    // A real answer beats the watchdog when both land on the same edge.
                    if (mul_done) begin
                        r_prod <= mul_prod;
                        r_err  <= 1'b0;
                    end else if (w_expire) begin
                        r_prod <= '0;
                        r_err  <= 1'b1;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_DONE: begin
                    r_ptr <= ~r_sel;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign mul_start = (r_state == ST_ISSUE);
    assign gnt0      = (r_state == ST_ISSUE) && (r_sel == 1'b0);
    assign gnt1      = (r_state == ST_ISSUE) && (r_sel == 1'b1);
    assign done0     = (r_state == ST_DONE)  && (r_sel == 1'b0);
    assign done1     = (r_state == ST_DONE)  && (r_sel == 1'b1);
    assign prod      = r_prod;
    assign err       = r_err;
    assign mul_opa   = r_opa;
    assign mul_opb   = r_opb;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a programmable-latency multiplier model.
module tb_mul_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [7:0]  opa0, opb0, opa1, opb1;
    logic        gnt0, gnt1, done0, done1;
    logic [15:0] prod;
    logic        err, busy, mul_start;
    logic [7:0]  mul_opa, mul_opb;
    logic        mul_done;
    logic [15:0] mul_prod;

    logic        model_done;
    logic        spur_done;
    int          lat;
    bit          never;
    int          rem;
    bit          pend;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_gnt0 = 0, n_gnt1 = 0, n_done0 = 0, n_done1 = 0;
    int          gnt_log[$];

    always #5 clk = ~clk;

    assign mul_done = model_done | spur_done;

    mul_arbiter #(.width(8), .TIMEOUT(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .opa0      (opa0),
        .opb0      (opb0),
        .req1      (req1),
        .opa1      (opa1),
        .opb1      (opb1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .prod      (prod),
        .err       (err),
        .busy      (busy),
        .mul_start (mul_start),
        .mul_opa   (mul_opa),
        .mul_opb   (mul_opb),
        .mul_done  (mul_done),
        .mul_prod  (mul_prod)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (gnt0) begin n_gnt0 <= n_gnt0 + 1; gnt_log.push_back(0); end
        if (gnt1) begin n_gnt1 <= n_gnt1 + 1; gnt_log.push_back(1); end
        if (done0) n_done0 <= n_done0 + 1;
        if (done1) n_done1 <= n_done1 + 1;
    end

    // Multiplier model: done is raised `lat` cycles after the start cycle.
    initial begin
        model_done = 1'b0;
        mul_prod   = '0;
        pend       = 1'b0;
        rem        = 0;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (!reset) begin
                pend = 1'b0;
            end else if (pend) begin
                rem = rem - 1;
                if (rem <= 0) begin
                    pend = 1'b0;
                    if (!never) begin
                        model_done = 1'b1;
                        mul_prod   = 16'(mul_opa) * 16'(mul_opb);
                    end
                end
            end else if (mul_start) begin
                pend = 1'b1;
                rem  = lat;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_sig(input int which, input int max_cyc, output int at, output bit ok);
        logic [3:0] ev;
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            ev = {done1, done0, gnt1, gnt0};
            if (ev[which]) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed cycle %0d expected completion", cyc);
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int  g_c, d_c, g2_c, base, snap1, snap2;
        bit  ok;
        logic [3:0] ord;

        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        opa0 = '0; opb0 = '0; opa1 = '0; opb1 = '0;
        spur_done = 1'b0; lat = 8; never = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_pulses", {gnt0, gnt1, done0, done1, mul_start, busy}, 0);
        chk("rst_prod_err", {prod, err}, 0);
        chk("rst_ops", {mul_opa, mul_opb}, 0);
        reset = 1'b1;
        @(negedge clk);

        // Single client, latency 8.
        snap1 = n_gnt1; snap2 = n_done1;
        opa0 = 8'hE9; opb0 = 8'hC3; req0 = 1'b1;
        wait_sig(0, 10, g_c, ok);
        chk("t1_gnt0_seen", ok, 1);
        chk("t1_start_with_gnt", mul_start, 1);
        chk("t1_ops_issue", {mul_opa, mul_opb}, 16'hE9C3);
        req0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("t1_ops_wait", {busy, mul_opa, mul_opb}, {1'b1, 16'hE9C3});
        wait_sig(2, 20, d_c, ok);
        chk("t1_done0_seen", ok, 1);
        chk("t1_latency", d_c - g_c, 9);
        chk("t1_prod", prod, 16'hB17B);
        chk("t1_err", err, 0);
        @(negedge clk);
        chk("t1_idle_held", {busy, prod}, {1'b0, 16'hB17B});
        chk("t1_no_client1", (n_gnt1 - snap1) + (n_done1 - snap2), 0);

        // Contention from reset: grants alternate 0,1,0,1.
        do_reset();
        lat = 3;
        opa0 = 8'h03; opb0 = 8'h05; opa1 = 8'h10; opb1 = 8'h10;
        base = gnt_log.size();
        req0 = 1'b1; req1 = 1'b1;
        for (int j = 0; j < 4; j++) begin
            wait_sig(2 + (j % 2), 30, d_c, ok);
            chk($sformatf("t2_done_seen_%0d", j), ok, 1);
            chk($sformatf("t2_prod_%0d", j), prod, (j % 2) ? 16'h0100 : 16'h000F);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("t2_ngrants", gnt_log.size() - base, 4);
        for (int i = 0; i < 4; i++)
            ord[i] = (gnt_log.size() > base + i) ? gnt_log[base + i][0] : 1'bx;
        chk("t2_order", ord, 4'b1010);

        // Watchdog: multiplier never answers.
        do_reset();
        never = 1'b1;
        opa0 = 8'h07; opb0 = 8'h09; req0 = 1'b1;
        wait_sig(0, 10, g_c, ok);
        chk("t3_gnt0_seen", ok, 1);
        req0 = 1'b0;
        wait_sig(2, 100, d_c, ok);
        chk("t3_done0_seen", ok, 1);
        chk("t3_timeout_cycles", d_c - g_c, 64);
        chk("t3_err_prod", {err, prod}, {1'b1, 16'h0000});
        never = 1'b0; lat = 2;
        @(negedge clk);
        req0 = 1'b1;
        wait_sig(0, 10, g_c, ok);
        req0 = 1'b0;
        wait_sig(2, 20, d_c, ok);
        chk("t3_recover_seen", ok, 1);
        chk("t3_recover", {err, prod}, {1'b0, 16'h003F});

        // Spurious done in IDLE, then in ISSUE.
        @(negedge clk);
        snap1 = n_done0 + n_done1;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        @(negedge clk);
        chk("t4_idle_spur", {busy, prod}, {1'b0, 16'h003F});
        lat = 6;
        opa1 = 8'h02; opb1 = 8'h03; req1 = 1'b1;
        wait_sig(1, 10, g_c, ok);
        chk("t4_gnt1_seen", ok, 1);
        spur_done = 1'b1; req1 = 1'b0;
        @(negedge clk);
        spur_done = 1'b0;
        chk("t4_issue_spur", {busy, prod}, {1'b1, 16'h003F});
        wait_sig(3, 20, d_c, ok);
        chk("t4_done_count", n_done0 + n_done1 - snap1, 0);
        chk("t4_latency", d_c - g_c, 7);
        chk("t4_prod", prod, 16'h0006);

        // Reset in the middle of WAIT.
        lat = 20;
        opa0 = 8'h11; opb0 = 8'h11; req0 = 1'b1;
        wait_sig(0, 10, g_c, ok);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("t5_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        chk("t5_rst_outs", {gnt0, gnt1, done0, done1, mul_start, busy, err}, 0);
        chk("t5_rst_prod", prod, 0);
        chk("t5_rst_ops", {mul_opa, mul_opb}, 0);
        @(negedge clk);
        reset = 1'b1;
        snap1 = n_done0 + n_done1;
        repeat (30) @(negedge clk);
        chk("t5_no_done", {n_done0 + n_done1 - snap1, 31'(busy)}, 0);

        // Back-to-back on client 1, latency 1.
        lat = 1;
        opa1 = 8'hFF; opb1 = 8'hFF; req1 = 1'b1;
        wait_sig(1, 10, g_c, ok);
        chk("t6_gnt1_seen", ok, 1);
        wait_sig(3, 10, d_c, ok);
        chk("t6_done1_seen", ok, 1);
        chk("t6_prod", prod, 16'hFE01);
        wait_sig(1, 10, g2_c, ok);
        chk("t6_gnt1_again", ok, 1);
        chk("t6_done_to_gnt", g2_c - d_c, 2);
        chk("t6_gnt_period", g2_c - g_c, 4);
        wait_sig(3, 10, d_c, ok);
        req1 = 1'b0;
        chk("t6_prod2", {ok, err, prod}, {1'b1, 1'b0, 16'hFE01});
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
